// File: rtl/sc_obstacle_spawner.sv
// ---------------------------------------------------------------------------
// sc_obstacle_spawner
//
// Purpose:
//   Turns the free-running LFSR random nibbles into enemy-car spawn events.
//   On each game tick (while idle) the right nibble decides whether to spawn
//   and the left nibble picks one of eight road columns. A spawn is offered
//   to the matrix writer as a one-hot pattern. After each accepted spawn the
//   block sits out GAP ticks. The same column is never used twice in a row.
//
// Handshake:
//   The pattern transfers on a rising clock edge where valid_OutHigh and
//   ready_InHigh are both high. While valid is high, the pattern stays
//   stable. The pattern is 0x00 whenever valid is low. Ready is ignored
//   while valid is low.
//
// Ports:
//   SC_SPAWN_CLOCK_50        in   system clock, rising edge
//   SC_SPAWN_RESET_InHigh    in   synchronous active-high reset
//   SC_SPAWN_clear_InLow     in   synchronous active-low game clear
//   SC_SPAWN_tick_InHigh     in   one-cycle game tick strobe
//   SC_SPAWN_RandomRightBUS  in   {4'b0, r[3:0]}; spawn when r < DENSITY
//   SC_SPAWN_RandomLeftBUS   in   {4'b0, l[3:0]}; l[2:0] is the column
//   SC_SPAWN_ready_InHigh    in   matrix writer ready
//   SC_SPAWN_PatternBUS      out  one-hot spawned column, 0x00 when idle
//   SC_SPAWN_valid_OutHigh   out  pattern valid
//   SC_SPAWN_CountBUS        out  accepted spawns, saturating at 255
//   SC_SPAWN_state_dbg_o     out  current FSM state (IDLE/SAMPLE/EMIT/COOL)
// ---------------------------------------------------------------------------
module sc_obstacle_spawner #(
    parameter int         DATAWIDTH = 8,
    parameter logic [3:0] DENSITY   = 4'd6,
    parameter int         GAP       = 2
) (
    input  logic                 SC_SPAWN_CLOCK_50,
    input  logic                 SC_SPAWN_RESET_InHigh,
    input  logic                 SC_SPAWN_clear_InLow,
    input  logic                 SC_SPAWN_tick_InHigh,
    input  logic [DATAWIDTH-1:0] SC_SPAWN_RandomRightBUS,
    input  logic [DATAWIDTH-1:0] SC_SPAWN_RandomLeftBUS,
    input  logic                 SC_SPAWN_ready_InHigh,
    output logic [DATAWIDTH-1:0] SC_SPAWN_PatternBUS,
    output logic                 SC_SPAWN_valid_OutHigh,
    output logic [7:0]           SC_SPAWN_CountBUS,
    output logic [1:0]           SC_SPAWN_state_dbg_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_COOL   = 2'd3;

    localparam logic [7:0]           GAP_INIT = 8'(GAP);
    localparam logic [DATAWIDTH-1:0] ONE      = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q,      state_d;
    logic [3:0]           r_q,          r_d;
    logic [2:0]           c_q,          c_d;
    logic [7:0]           gap_q,        gap_d;
    logic                 last_valid_q, last_valid_d;
    logic [2:0]           last_col_q,   last_col_d;
    logic                 valid_q,      valid_d;
    logic [DATAWIDTH-1:0] pattern_q,    pattern_d;
    logic [7:0]           count_q,      count_d;

    logic [2:0]           col;

    // Upper bus bits and left bit 3 carry no meaning for this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{SC_SPAWN_RandomRightBUS[DATAWIDTH-1:4],
                               SC_SPAWN_RandomLeftBUS[DATAWIDTH-1:3]};

    // If the previous spawn used this column, move one column right.
    // The 3-bit add wraps column 7 back to 0.
    assign col = (last_valid_q && (c_q == last_col_q)) ? (c_q + 3'd1) : c_q;

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        c_d          = c_q;
        gap_d        = gap_q;
        last_valid_d = last_valid_q;
        last_col_d   = last_col_q;
        valid_d      = valid_q;
        pattern_d    = pattern_q;
        count_d      = count_q;

        case (state_q)
            S_IDLE: begin
                if (SC_SPAWN_tick_InHigh) begin
                    r_d     = SC_SPAWN_RandomRightBUS[3:0];
                    c_d     = SC_SPAWN_RandomLeftBUS[2:0];
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (r_q >= DENSITY) begin
                    state_d = S_IDLE;
                end else begin
                    pattern_d    = ONE << col;
                    valid_d      = 1'b1;
                    last_col_d   = col;
                    last_valid_d = 1'b1;
                    state_d      = S_EMIT;
                end
            end
            S_EMIT: begin
                if (valid_q && SC_SPAWN_ready_InHigh) begin
                    valid_d   = 1'b0;
                    pattern_d = '0;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    gap_d   = GAP_INIT;
                    state_d = (GAP != 0) ? S_COOL : S_IDLE;
                end
            end
            S_COOL: begin
                // The tick that empties the gap only returns to IDLE.
                // The next tick is the first one sampled.
                if (SC_SPAWN_tick_InHigh) begin
                    if (gap_q <= 8'd1) begin
                        gap_d   = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SC_SPAWN_CLOCK_50) begin
        if (SC_SPAWN_RESET_InHigh) begin
            state_q      <= S_IDLE;
            r_q          <= 4'd0;
            c_q          <= 3'd0;
            gap_q        <= 8'd0;
            last_valid_q <= 1'b0;
            last_col_q   <= 3'd0;
            valid_q      <= 1'b0;
            pattern_q    <= '0;
            count_q      <= 8'd0;
        end else if (!SC_SPAWN_clear_InLow) begin
            // Game clear drops any pending offer without counting it.
            // The spawn count is kept.
            state_q      <= S_IDLE;
            gap_q        <= 8'd0;
            last_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            pattern_q    <= '0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            gap_q        <= gap_d;
            last_valid_q <= last_valid_d;
            last_col_q   <= last_col_d;
            valid_q      <= valid_d;
            pattern_q    <= pattern_d;
            count_q      <= count_d;
        end
    end

    assign SC_SPAWN_PatternBUS    = pattern_q;
    assign SC_SPAWN_valid_OutHigh = valid_q;
    assign SC_SPAWN_CountBUS      = count_q;
    assign SC_SPAWN_state_dbg_o   = state_q;

endmodule

// File: tb/tb_sc_obstacle_spawner.sv
module tb_sc_obstacle_spawner;

    logic       clk;
    logic       rst;
    logic       clr_n;
    logic       tick;
    logic [7:0] right_bus;
    logic [7:0] left_bus;
    logic       ready;
    logic [7:0] pattern;
    logic       valid;
    logic [7:0] count;
    logic [1:0] state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_count = 8'd0;

    sc_obstacle_spawner dut (
        .SC_SPAWN_CLOCK_50       (clk),
        .SC_SPAWN_RESET_InHigh   (rst),
        .SC_SPAWN_clear_InLow    (clr_n),
        .SC_SPAWN_tick_InHigh    (tick),
        .SC_SPAWN_RandomRightBUS (right_bus),
        .SC_SPAWN_RandomLeftBUS  (left_bus),
        .SC_SPAWN_ready_InHigh   (ready),
        .SC_SPAWN_PatternBUS     (pattern),
        .SC_SPAWN_valid_OutHigh  (valid),
        .SC_SPAWN_CountBUS       (count),
        .SC_SPAWN_state_dbg_o    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // driver tasks: inputs change and outputs are read #1 after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input logic [7:0] rb, input logic [7:0] lb);
        right_bus = rb;
        left_bus  = lb;
        tick      = 1'b1;
        step();
        tick      = 1'b0;
    endtask

    task automatic do_clear();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
    endtask

    // Spawn with ready=1, capture the offered beat, then burn the two cool ticks.
    task automatic spawn_cool(input logic [7:0] rb, input logic [7:0] lb,
                              output logic v, output logic [7:0] p);
        ready = 1'b1;
        pulse_tick(rb, lb);
        step();
        v = valid;
        p = pattern;
        step();
        pulse_tick(8'hFF, 8'h00);
        repeat (3) step();
        pulse_tick(8'hFF, 8'h00);
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_n = 1'b1; tick = 1'b0; ready = 1'b0;
        right_bus = 8'h00; left_bus = 8'h00;
        step();
        step();
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", valid);
        else pass_cnt++;
        total_cnt++;
        if (pattern !== 8'h00) $display("FAIL reset_pattern: got %h expected 00", pattern);
        else pass_cnt++;
        total_cnt++;
        if (count !== 8'h00) $display("FAIL reset_count: got %0d expected 0", count);
        else pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        pulse_tick(8'h03, 8'h05);
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL basic_n1_valid: got %0b expected 0", valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (valid !== 1'b1 || pattern !== 8'h20)
            $display("FAIL basic_n2: got valid=%0b pat=%h expected valid=1 pat=20", valid, pattern);
        else pass_cnt++;
        step();
        exp_count++;
        total_cnt++;
        if (valid !== 1'b0 || pattern !== 8'h00 || count !== exp_count)
            $display("FAIL basic_n3: got valid=%0b pat=%h cnt=%0d expected 0 00 %0d",
                     valid, pattern, count, exp_count);
        else pass_cnt++;
        do_clear();
    endtask

    task automatic test_density();
        logic seen;
        seen = 1'b0;
        ready = 1'b1;
        pulse_tick(8'h06, 8'h00);
        for (int i = 0; i < 10; i++) begin
            if (valid !== 1'b0) seen = 1'b1;
            step();
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL density_eq_no_spawn: got valid seen=1 expected 0");
        else pass_cnt++;
        total_cnt++;
        if (count !== exp_count) $display("FAIL density_count: got %0d expected %0d", count, exp_count);
        else pass_cnt++;
        // r=5 with junk upper bits spawns; left bit 3 ignored (0x0B -> column 3)
        pulse_tick(8'hF5, 8'hFB);
        step();
        total_cnt++;
        if (valid !== 1'b1 || pattern !== 8'h08)
            $display("FAIL density_below: got valid=%0b pat=%h expected 1 08", valid, pattern);
        else pass_cnt++;
        step();
        exp_count++;
        do_clear();
    endtask

    task automatic test_backpressure();
        logic bad;
        bad = 1'b0;
        ready = 1'b0;
        pulse_tick(8'h00, 8'h05);
        step();
        for (int i = 0; i < 5; i++) begin
            if (valid !== 1'b1 || pattern !== 8'h20) bad = 1'b1;
            step();
        end
        total_cnt++;
        if (bad !== 1'b0 || count !== exp_count)
            $display("FAIL bp_hold: got unstable=%0b cnt=%0d expected 0 %0d", bad, count, exp_count);
        else pass_cnt++;
        ready = 1'b1;
        step();
        exp_count++;
        total_cnt++;
        if (valid !== 1'b0 || pattern !== 8'h00)
            $display("FAIL bp_release: got valid=%0b pat=%h expected 0 00", valid, pattern);
        else pass_cnt++;
        repeat (3) step();
        total_cnt++;
        if (count !== exp_count) $display("FAIL bp_count_once: got %0d expected %0d", count, exp_count);
        else pass_cnt++;
        do_clear();
    endtask

    task automatic test_repeat_column();
        logic       v;
        logic [7:0] p;
        logic [7:0] lefts [5]  = '{8'h05, 8'h05, 8'h07, 8'h07, 8'h05};
        logic [7:0] expect_p [5] = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h20};
        for (int i = 0; i < 5; i++) begin
            if (i == 4) do_clear();
            spawn_cool(8'h00, lefts[i], v, p);
            exp_count++;
            total_cnt++;
            if (v !== 1'b1 || p !== expect_p[i])
                $display("FAIL repeat_col_%0d: got valid=%0b pat=%h expected 1 %h", i, v, p, expect_p[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (count !== exp_count) $display("FAIL repeat_count: got %0d expected %0d", count, exp_count);
        else pass_cnt++;
        do_clear();
    endtask

    task automatic test_gap();
        logic seen;
        ready = 1'b1;
        pulse_tick(8'h00, 8'h02);
        step();
        step();
        exp_count++;
        for (int t = 0; t < 2; t++) begin
            seen = 1'b0;
            pulse_tick(8'h00, 8'h03);
            for (int i = 0; i < 3; i++) begin
                if (valid !== 1'b0) seen = 1'b1;
                step();
            end
            total_cnt++;
            if (seen !== 1'b0) $display("FAIL gap_tick_%0d: got spawn=1 expected 0", t + 1);
            else pass_cnt++;
        end
        pulse_tick(8'h00, 8'h03);
        step();
        total_cnt++;
        if (valid !== 1'b1 || pattern !== 8'h08)
            $display("FAIL gap_third_tick: got valid=%0b pat=%h expected 1 08", valid, pattern);
        else pass_cnt++;
        step();
        exp_count++;
        do_clear();
    endtask

    task automatic test_clear_mid_emit();
        ready = 1'b0;
        pulse_tick(8'h00, 8'h01);
        step();
        total_cnt++;
        if (valid !== 1'b1 || pattern !== 8'h02)
            $display("FAIL clr_setup: got valid=%0b pat=%h expected 1 02", valid, pattern);
        else pass_cnt++;
        ready = 1'b1;
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        total_cnt++;
        if (valid !== 1'b0 || pattern !== 8'h00 || count !== exp_count || state_dbg !== 2'd0)
            $display("FAIL clr_mid_emit: got valid=%0b pat=%h cnt=%0d st=%0d expected 0 00 %0d 0",
                     valid, pattern, count, state_dbg, exp_count);
        else pass_cnt++;
        repeat (3) step();
        total_cnt++;
        if (count !== exp_count) $display("FAIL clr_count_hold: got %0d expected %0d", count, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_saturate();
        logic       v;
        logic [7:0] p;
        logic [7:0] lb;
        logic [7:0] exp_p;
        do_clear();
        for (int i = 0; i < 300; i++) begin
            lb    = 8'(i % 8);
            exp_p = 8'h01 << (i % 8);
            spawn_cool(8'h00, lb, v, p);
            if (exp_count != 8'hFF) exp_count++;
            total_cnt++;
            if (v !== 1'b1 || p !== exp_p)
                $display("FAIL b2b_pattern_%0d: got valid=%0b pat=%h expected 1 %h", i, v, p, exp_p);
            else pass_cnt++;
        end
        total_cnt++;
        if (count !== 8'd255) $display("FAIL count_saturate: got %0d expected 255", count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        ready = 1'b0;
        pulse_tick(8'h00, 8'h04);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count = 8'd0;
        total_cnt++;
        if (valid !== 1'b0 || pattern !== 8'h00 || count !== exp_count || state_dbg !== 2'd0)
            $display("FAIL reset_mid_op: got valid=%0b pat=%h cnt=%0d st=%0d expected 0 00 0 0",
                     valid, pattern, count, state_dbg);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_density();
        test_backpressure();
        test_repeat_column();
        test_gap();
        test_clear_mid_emit();
        test_back_to_back_saturate();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
